// File: rtl/opb_p2s_pkg.sv
// Shared types and helpers for the PPC-to-Simulink OPB control register.
// Holds the FSM state type, lane count and OPB/user bit-order conversions.
package opb_p2s_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAck,
      StTurn
   } state_e;

   localparam int unsigned NumLanes = 4;

   // OPB numbers bit 0 as the MSB; user logic sees [31:0] with user[31-i] = OPB bit i.
   function automatic logic [31:0] opb_to_user(input logic [0:31] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[31-i] = v[i];
      end
      return r;
   endfunction

   function automatic logic [0:31] user_to_opb(input logic [31:0] v);
      logic [0:31] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/opb_be_merge.sv
// Combinational byte-lane merge: lanes with be_i[k] set take new data, the rest keep old.
// Lane k is OPB DBus[8k:8k+7], i.e. user bits [31-8k -: 8].
module opb_be_merge
   import opb_p2s_pkg::*;
(
   input  logic [31:0]         old_i,
   input  logic [31:0]         new_i,
   input  logic [NumLanes-1:0] be_i,
   output logic [31:0]         merged_o
);

   always_comb begin
      merged_o = old_i;
      for (int k = 0; k < NumLanes; k++) begin
         if (be_i[k]) begin
            merged_o[31-8*k -: 8] = new_i[31-8*k -: 8];
         end
      end
   end

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// Software-writable 32-bit OPB control register driving user fabric logic.
// Define OPB_P2S_READBACK_EN to return the register contents on reads.
module opb_register_ppc2simulink
   import opb_p2s_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR    = 32'hFFFF_FFFF,
   parameter logic [31:0] C_HIGHADDR    = 32'h0000_0000,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter string       C_FAMILY      = "virtex6",
   parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
   input  logic        OPB_Clk,
   input  logic        OPB_Rst,
   input  logic [0:31] OPB_ABus,
   input  logic [0:3]  OPB_BE,
   input  logic [0:31] OPB_DBus,
   input  logic        OPB_RNW,
   input  logic        OPB_select,
   input  logic        OPB_seqAddr,
   output logic [0:31] Sl_DBus,
   output logic        Sl_xferAck,
   output logic        Sl_errAck,
   output logic        Sl_retry,
   output logic        Sl_toutSup,
   output logic [31:0] user_data_out,
   output logic        user_data_wr
);

   localparam bit unused_cfg = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) && (C_FAMILY != "");
   logic unused_seq;
   assign unused_seq = OPB_seqAddr;

   state_e            state_q, state_d;
   logic [31:0]       reg_q, reg_d;
   logic              ack_q, ack_d;
   logic              wr_q, wr_d;
   logic [31:0]       abus;
   logic              hit;
   logic [NumLanes-1:0] be_lane;
   logic [31:0]       merged;

   assign abus    = OPB_ABus;
   assign hit     = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
   assign be_lane = {OPB_BE[3], OPB_BE[2], OPB_BE[1], OPB_BE[0]};

   opb_be_merge u_be_merge (
      .old_i    (reg_q),
      .new_i    (opb_to_user(OPB_DBus)),
      .be_i     (be_lane),
      .merged_o (merged)
   );

   always_comb begin
      state_d = state_q;
      reg_d   = reg_q;
      ack_d   = 1'b0;
      wr_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (hit) begin
               state_d = StAck;
               ack_d   = 1'b1;
               if (!OPB_RNW) begin
                  reg_d = merged;
                  wr_d  = |OPB_BE;
               end
            end
         end
         StAck:   state_d = StTurn;
         // Select is still high at the edge ending the ack cycle; skip it.
         StTurn:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         state_q <= StIdle;
         reg_q   <= C_RESET_VALUE;
         ack_q   <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         reg_q   <= reg_d;
         ack_q   <= ack_d;
         wr_q    <= wr_d;
      end
   end

`ifdef OPB_P2S_READBACK_EN
   logic [0:31] dbus_q, dbus_d;

   always_comb begin
      dbus_d = '0;
      if ((state_q == StIdle) && hit && OPB_RNW) begin
         dbus_d = user_to_opb(reg_q);
      end
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         dbus_q <= '0;
      end else begin
         dbus_q <= dbus_d;
      end
   end

   assign Sl_DBus = dbus_q;
`else
   assign Sl_DBus = '0;
`endif

   assign Sl_xferAck    = ack_q;
   assign Sl_errAck     = 1'b0;
   assign Sl_retry      = 1'b0;
   assign Sl_toutSup    = 1'b0;
   assign user_data_out = reg_q;
   assign user_data_wr  = wr_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Directed self-checking bench for opb_register_ppc2simulink.
// Read-data expectations follow OPB_P2S_READBACK_EN when it is defined.
module tb_opb_register_ppc2simulink;

   localparam logic [31:0] Base  = 32'h4000_0000;
   localparam logic [31:0] High  = 32'h4000_00FF;
   localparam logic [31:0] RstV  = 32'hA5A5_0001;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:31] abus;
   logic [0:3]  be;
   logic [0:31] dbus;
   logic        rnw;
   logic        sel;
   logic        seq;
   logic [0:31] sl_dbus;
   logic        sl_ack, sl_err, sl_retry, sl_tout;
   logic [31:0] user_data_out;
   logic        user_data_wr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   opb_register_ppc2simulink #(
      .C_BASEADDR    (Base),
      .C_HIGHADDR    (High),
      .C_OPB_AWIDTH  (32),
      .C_OPB_DWIDTH  (32),
      .C_FAMILY      ("virtex6"),
      .C_RESET_VALUE (RstV)
   ) dut (
      .OPB_Clk       (clk),
      .OPB_Rst       (rst),
      .OPB_ABus      (abus),
      .OPB_BE        (be),
      .OPB_DBus      (dbus),
      .OPB_RNW       (rnw),
      .OPB_select    (sel),
      .OPB_seqAddr   (seq),
      .Sl_DBus       (sl_dbus),
      .Sl_xferAck    (sl_ack),
      .Sl_errAck     (sl_err),
      .Sl_retry      (sl_retry),
      .Sl_toutSup    (sl_tout),
      .user_data_out (user_data_out),
      .user_data_wr  (user_data_wr)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One write beat: drives the hit, checks the ack cycle, drops select, checks turnaround.
   task automatic write_beat(input logic [31:0] data, input logic [3:0] ben,
                             input logic [31:0] exp_val, input logic exp_wr);
      abus = Base; rnw = 1'b0; be = ben; dbus = data; sel = 1'b1;
      tick();
      check("wr_ack", {31'b0, sl_ack}, 32'd1);
      check("wr_strobe", {31'b0, user_data_wr}, {31'b0, exp_wr});
      check("wr_value", user_data_out, exp_val);
      check("wr_dbus", sl_dbus, 32'h0);
      sel = 1'b0;
      tick();
      check("wr_turn_ack", {31'b0, sl_ack}, 32'd0);
      check("wr_turn_strobe", {31'b0, user_data_wr}, 32'd0);
      tick();
   endtask

   initial begin
      logic [31:0] exp_rd;
      int          acks;
      logic        prev_ack;

      rst = 1'b1; sel = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b0; seq = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_value", user_data_out, RstV);
      check("rst_strobe", {31'b0, user_data_wr}, 32'd0);
      check("rst_ack", {31'b0, sl_ack}, 32'd0);
      check("rst_dbus", sl_dbus, 32'h0);
      check("tied_zero", {29'b0, sl_err, sl_retry, sl_tout}, 32'd0);

      write_beat(32'h1234_5678, 4'b1111, 32'h1234_5678, 1'b1);
      write_beat(32'hFFFF_FFFF, 4'b0100, 32'h12FF_5678, 1'b1);
      write_beat(32'h0000_0000, 4'b0000, 32'h12FF_5678, 1'b0);

`ifdef OPB_P2S_READBACK_EN
      exp_rd = 32'h12FF_5678;
`else
      exp_rd = 32'h0;
`endif
      abus = Base + 32'd8; rnw = 1'b1; be = 4'b0001; sel = 1'b1;
      check("rd_pre_ack", {31'b0, sl_ack}, 32'd0);
      tick();
      check("rd_ack", {31'b0, sl_ack}, 32'd1);
      check("rd_dbus", sl_dbus, exp_rd);
      check("rd_no_strobe", {31'b0, user_data_wr}, 32'd0);
      sel = 1'b0;
      tick();
      check("rd_dbus_after", sl_dbus, 32'h0);
      check("rd_ack_after", {31'b0, sl_ack}, 32'd0);
      tick();

      // Select held high across four beats: acks on cycles 1, 4, 7, 10.
      abus = Base + 32'd4; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
      acks = 0; prev_ack = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         tick();
         check("burst_ack", {31'b0, sl_ack}, {31'b0, (cyc <= 10) && (cyc % 3 == 1)});
         check("burst_gap", {31'b0, prev_ack && sl_ack}, 32'd0);
         if (sl_ack) acks++;
         prev_ack = sl_ack;
         if (cyc == 10) sel = 1'b0;
      end
      check("burst_count", acks, 32'd4);
      check("burst_value", user_data_out, 32'h12FF_5678);

      // Addresses just above and just below the window are never acked.
      acks = 0;
      rnw = 1'b0; be = 4'b1111; dbus = 32'hCAFE_F00D; sel = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         abus = (cyc < 6) ? High + 32'd1 : Base - 32'd4;
         tick();
         if (sl_ack) acks++;
      end
      sel = 1'b0;
      check("oow_acks", acks, 32'd0);
      check("oow_value", user_data_out, 32'h12FF_5678);
      tick();

      // Reset during the ack cycle of a write, with select still high.
      abus = Base; rnw = 1'b0; be = 4'b1111; dbus = 32'hDEAD_BEEF; sel = 1'b1;
      tick();
      check("rstack_ack", {31'b0, sl_ack}, 32'd1);
      check("rstack_written", user_data_out, 32'hDEAD_BEEF);
      rst = 1'b1;
      tick();
      check("rstack_value", user_data_out, RstV);
      check("rstack_no_ack", {31'b0, sl_ack}, 32'd0);
      check("rstack_no_strobe", {31'b0, user_data_wr}, 32'd0);
      // FSM must be back in idle: a fresh hit is acked on the very next edge.
      rst = 1'b0; dbus = 32'h0BAD_F00D;
      tick();
      check("rstack_idle_ack", {31'b0, sl_ack}, 32'd1);
      check("rstack_idle_value", user_data_out, 32'h0BAD_F00D);
      sel = 1'b0;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/opb_register_ppc2simulink.md
# opb_register_ppc2simulink

Software-writable 32-bit control register on the OPB bus: the PowerPC writes it, user fabric logic reads it continuously on `user_data_out`. It is the write-direction counterpart of the simulink2ppc status register and sits on the same OPB segment. It provides address decode, byte-lane merging, a registered ack handshake and a one-cycle update strobe to user logic. Everything runs on the single OPB clock.

## Interface
- C_BASEADDR, 32'hFFFFFFFF: first byte address of the decoded window.
- C_HIGHADDR, 32'h00000000: last byte address of the decoded window. All words in the window alias the one register.
- C_OPB_AWIDTH, 32: address width. Only 32 is supported.
- C_OPB_DWIDTH, 32: data width. Only 32 is supported.
- C_FAMILY, "virtex6": target family string. Informational only.
- C_RESET_VALUE, 32'h00000000: register contents after reset, in user bit order.
- OPB_Clk  in  1: the only clock. All user-side ports are synchronous to it.
- OPB_Rst  in  1: reset, synchronous, active-high.
- OPB_ABus  in  [0:31]: address.
- OPB_BE  in  [0:3]: byte enables. BE[0] enables DBus[0:7].
- OPB_DBus  in  [0:31]: write data. Bit 0 is the MSB.
- OPB_RNW  in  1: 1 = read, 0 = write.
- OPB_select  in  1: transfer request.
- OPB_seqAddr  in  1: ignored.
- Sl_DBus  out  [0:31]: read data. All zeros except during the ack cycle.
- Sl_xferAck  out  1: one-cycle transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each: tied to 0.
- user_data_out  out  [31:0]: current register value. user_data_out[31-i] = OPB bit i.
- user_data_wr  out  1: one-cycle strobe, high in the first cycle the new value is visible.

## Operation
- Hit condition: `OPB_select` high and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- The FSM has three states:
  - IDLE to ACK on a hit. The access is captured at this edge.
  - ACK to TURN unconditionally.
  - TURN to IDLE unconditionally.
- TURN exists because `OPB_select` is still high at the edge that ends the ack cycle. Ignoring that edge prevents a double ack.
- Bursts are served as independent beats, each taking 3 cycles.
- Write (RNW = 0): for each lane k with BE[k] = 1, register lane k takes OPB_DBus[8k:8k+7]. Lanes with BE[k] = 0 keep their value.
  - `user_data_wr` pulses in the ACK cycle only if at least one BE bit is set.
  - A write with BE = 0000 is still acked, but changes nothing and produces no strobe.
- Read (RNW = 1): `Sl_DBus` carries the register contents in OPB bit order during the ACK cycle, and zeros otherwise. Byte enables do not mask read data.
- Reset values:
  - FSM = IDLE.
  - Sl_xferAck = 0, Sl_DBus = 0, user_data_wr = 0.
  - Register = C_RESET_VALUE.
- Reset in ACK or TURN: return to IDLE on the next edge. No ack and no strobe follow. The register takes C_RESET_VALUE even if a write was captured in the same cycle, because reset wins.
- Hit while in ACK or TURN: not seen. It is evaluated again on the first IDLE cycle.
- Non-hit select: never acked. The master times out, which is correct OPB behaviour for another slave's address.

## Timing
- Hit sampled at edge E.
  - Sl_xferAck, Sl_DBus, user_data_wr and the new user_data_out are all valid in the cycle after E.
  - Latency from hit to ack is 1 cycle.
- All outputs are registered. There is no combinational path from OPB inputs to outputs.
- Minimum spacing between consecutive acks is 3 cycles.

## Configuration
- Macro: `OPB_P2S_READBACK_EN`.
- Defined: reads return the register contents as described in Operation.
- Undefined: reads are still acked with identical timing, but Sl_DBus stays all zeros. The readback mux and its flops are removed.

## Structure
- Shared package `opb_p2s_pkg` holds:
  - the state enum IDLE, ACK, TURN;
  - the lane count constant (4);
  - the bit-order reversal function between OPB [0:31] and user [31:0] order.
- Sub-module `opb_be_merge`: combinational byte-lane merge of old value, new data and BE, producing the next register value.
- Top level holds the FSM, address decode and output registers.

## Test plan
- Reset with C_RESET_VALUE = 32'hA5A5_0001 -> user_data_out = 32'hA5A5_0001, user_data_wr = 0, Sl_xferAck = 0.
- Write 32'h1234_5678 with BE = 1111 to C_BASEADDR -> ack exactly 1 cycle after the hit, user_data_out = 32'h1234_5678, one user_data_wr pulse in the ack cycle.
- Write 32'hFFFF_FFFF with BE = 0100 over 32'h1234_5678 -> user_data_out = 32'h12FF_5678. Then a BE = 0000 write -> acked, value unchanged, no strobe.
- Read after the above:
  - with the macro defined -> Sl_DBus = 32'h12FF_5678 for the single ack cycle, 0 otherwise;
  - without the macro -> Sl_DBus = 0 with the same ack timing.
- Select held high for 4 beats to C_BASEADDR + 4 -> exactly 4 acks spaced 3 cycles apart, never two acks in consecutive cycles.
- Two further cases:
  - out-of-window address -> no ack ever;
  - OPB_Rst asserted in the ACK cycle of a write -> next cycle FSM is IDLE and register = C_RESET_VALUE.
